// File: rtl/apb_reg_pkg.sv
// Shared types and register map for the APB bridge in front of the counter register block.
package apb_reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [9:0] CTRL_ADDR  = 10'h000;
    localparam logic [9:0] COUNT_ADDR = 10'h004;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CLR_BIT   = 1;

endpackage

// File: rtl/apb_reg_bridge_irq_edge_latch.sv
// Sticky overflow interrupt: sets on a sampled rising edge of overflow, cleared by a
// control-register clear command; a set in the same cycle as a clear takes priority.
module irq_edge_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic overflow,
    input  logic clr,
    output logic irq
);

    logic overflow_q;

    // Edge detect on overflow and set-priority sticky latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            irq        <= 1'b0;
        end else begin
            overflow_q <= overflow;
            if (overflow && !overflow_q) begin
                irq <= 1'b1;
            end else if (clr) begin
                irq <= 1'b0;
            end else begin
                irq <= irq;
            end
        end
    end

endmodule

// File: rtl/apb_reg_bridge.sv
// APB3 slave front-end turning transfers into single-cycle register strobes.
// Define APB_ADDR_CHECK_EN to reject unmapped addresses and writes to COUNT_ADDR with pslverr.
module apb_reg_bridge
    import apb_reg_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              overflow,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(CTRL_ADDR);

    state_t state_r;
    logic   addr_ok_s;
    logic   clr_s;

`ifdef APB_ADDR_CHECK_EN
    localparam logic [ADDR_W-1:0] COUNT_A = ADDR_W'(COUNT_ADDR);

    // Only the control register is writable; the count register is read-only
    always_comb begin
        addr_ok_s = 1'b0;
        if (paddr == CTRL_A) begin
            addr_ok_s = 1'b1;
        end else if ((paddr == COUNT_A) && !pwrite) begin
            addr_ok_s = 1'b1;
        end else begin
            addr_ok_s = 1'b0;
        end
    end

    assign pslverr = (state_r == ST_ERR);
`else
    assign addr_ok_s = 1'b1;
    assign pslverr   = 1'b0;
`endif

    assign pready = (state_r == ST_WR) || (state_r == ST_RD2) || (state_r == ST_ERR);
    assign prdata = (state_r == ST_RD2) ? rdata : {DATA_W{1'b0}};

    // Transfer sequencer with registered strobes and held address/data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            addr    <= {ADDR_W{1'b0}};
            wdata   <= {DATA_W{1'b0}};
        end else begin
            wr_en <= 1'b0;
            rd_en <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // A bare access phase without setup is ignored
                    if (psel && !penable) begin
                        addr  <= paddr;
                        wdata <= pwdata;
                        if (!addr_ok_s) begin
                            state_r <= ST_ERR;
                        end else if (pwrite) begin
                            state_r <= ST_WR;
                            wr_en   <= 1'b1;
                        end else begin
                            state_r <= ST_RD1;
                            rd_en   <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WR:   state_r <= ST_IDLE;
                ST_RD1:  state_r <= psel ? ST_RD2 : ST_IDLE;
                ST_RD2:  state_r <= ST_IDLE;
                ST_ERR:  state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // The clear command is taken from the held write data while the write strobe is high
    assign clr_s = wr_en && (addr == CTRL_A) && wdata[CTRL_CLR_BIT];

    irq_edge_latch u_irq (
        .clk      (clk),
        .rst_n    (rst_n),
        .overflow (overflow),
        .clr      (clr_s),
        .irq      (irq)
    );

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Self-checking bench for apb_reg_bridge: transaction-level expectations compared every cycle.
module tb_apb_reg_bridge;

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [9:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr, wr_en, rd_en;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        overflow;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic run = 1'b0;

    logic        exp_wr_en = 1'b0, exp_rd_en = 1'b0, exp_pready = 1'b0, exp_pslverr = 1'b0;
    logic [31:0] exp_prdata = 32'd0;
    logic [9:0]  exp_addr = 10'd0;
    logic [31:0] exp_wdata = 32'd0;
    logic        clr_now = 1'b0;
    logic        exp_irq;

    logic        cap_wr, cap_rd, cap_pready1, cap_pslverr1, cap_pready2;
    logic [31:0] cap_prdata1, cap_prdata2, cap_wdata1;
    logic [9:0]  cap_addr1;

    int cyc = 0;
    int last_rise = -1;
    int last_clr = -1;
    logic ov_prev = 1'b0;

    apb_reg_bridge dut (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .overflow(overflow), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // irq is high iff the most recent sampled overflow rise is no older than the most recent clear
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0; last_rise <= -1; last_clr <= -1; ov_prev <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (overflow && !ov_prev) last_rise <= cyc;
            if (clr_now) last_clr <= cyc;
            ov_prev <= overflow;
        end
    end
    assign exp_irq = (last_rise >= 0) && (last_rise >= last_clr);

    // Every-cycle comparison against the expectations
    always @(negedge clk) begin
        if (run && rst_n) begin
            chk("wr_en", 32'(wr_en), 32'(exp_wr_en));
            chk("rd_en", 32'(rd_en), 32'(exp_rd_en));
            chk("pready", 32'(pready), 32'(exp_pready));
            chk("pslverr", 32'(pslverr), 32'(exp_pslverr));
            chk("prdata", prdata, exp_prdata);
            chk("addr", 32'(addr), 32'(exp_addr));
            chk("wdata", wdata, exp_wdata);
            chk("irq", 32'(irq), 32'(exp_irq));
        end
    end

    function automatic bit is_err(input logic [9:0] a, input bit w);
`ifdef APB_ADDR_CHECK_EN
        return !((a == 10'h000) || ((a == 10'h004) && !w));
`else
        return 1'b0;
`endif
    endfunction

    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        exp_wr_en = 1'b0; exp_rd_en = 1'b0; exp_pready = 1'b0;
        exp_pslverr = 1'b0; exp_prdata = 32'd0; clr_now = 1'b0;
    endtask

    task automatic idle(input logic ov);
        cyc_start();
        psel = 1'b0; penable = 1'b0; overflow = ov; rdata = JUNK;
        set_idle_exp();
    endtask

    task automatic capture_t1();
        @(negedge clk);
        cap_wr = wr_en; cap_rd = rd_en; cap_pready1 = pready; cap_pslverr1 = pslverr;
        cap_prdata1 = prdata; cap_addr1 = addr; cap_wdata1 = wdata;
    endtask

    task automatic apb_write(input logic [9:0] a, input logic [31:0] d, input logic ov_t1);
        bit err;
        err = is_err(a, 1'b1);
        cyc_start();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; rdata = JUNK;
        set_idle_exp();
        cyc_start();
        penable = 1'b1; overflow = ov_t1;
        set_idle_exp();
        exp_addr = a; exp_wdata = d; exp_pready = 1'b1;
        if (err) begin
            exp_pslverr = 1'b1;
        end else begin
            exp_wr_en = 1'b1;
            clr_now = (a == 10'h000) && d[1];
        end
        capture_t1();
    endtask

    task automatic apb_read(input logic [9:0] a, input logic [31:0] rv);
        bit err;
        logic [31:0] pw;
        err = is_err(a, 1'b0);
        pw = 32'hC0DE_0000 | {22'd0, a};
        cyc_start();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a; pwdata = pw; rdata = JUNK;
        set_idle_exp();
        cyc_start();
        penable = 1'b1;
        set_idle_exp();
        exp_addr = a; exp_wdata = pw;
        if (err) begin
            exp_pready = 1'b1; exp_pslverr = 1'b1;
        end else begin
            exp_rd_en = 1'b1;
        end
        capture_t1();
        if (!err) begin
            cyc_start();
            rdata = rv;
            set_idle_exp();
            exp_pready = 1'b1; exp_prdata = rv;
            @(negedge clk);
            cap_pready2 = pready; cap_prdata2 = prdata;
        end
    endtask

    initial begin
        logic b2b_wr;
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 10'd0; pwdata = 32'd0; rdata = JUNK; overflow = 1'b0;

        // Reset state
        @(posedge clk);
        #3;
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        run = 1'b1;
        idle(1'b0);

        // Single write
        apb_write(10'h000, 32'h0000_0001, 1'b0);
        chk("wr_t1_wr_en", 32'(cap_wr), 32'd1);
        chk("wr_t1_pready", 32'(cap_pready1), 32'd1);
        chk("wr_t1_pslverr", 32'(cap_pslverr1), 32'd0);
        chk("wr_t1_addr", 32'(cap_addr1), 32'h000);
        chk("wr_t1_wdata", cap_wdata1, 32'h1);
        idle(1'b0);

        // Single read with one wait state
        apb_read(10'h004, 32'h0000_002A);
        chk("rd_t1_rd_en", 32'(cap_rd), 32'd1);
        chk("rd_t1_pready", 32'(cap_pready1), 32'd0);
        chk("rd_t1_prdata", cap_prdata1, 32'd0);
        chk("rd_t2_pready", 32'(cap_pready2), 32'd1);
        chk("rd_t2_prdata", cap_prdata2, 32'h0000_002A);
        idle(1'b0);

        // Overflow edge sets irq; it stays after overflow falls; clear command drops it
        idle(1'b1);
        idle(1'b0);
        @(negedge clk);
        chk("irq_set", 32'(irq), 32'd1);
        idle(1'b0);
        @(negedge clk);
        chk("irq_sticky", 32'(irq), 32'd1);
        apb_write(10'h000, 32'h0000_0002, 1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("irq_cleared", 32'(irq), 32'd0);

        // Overflow edge in the same cycle as the clear: set wins
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        apb_write(10'h000, 32'h0000_0002, 1'b1);
        idle(1'b0);
        @(negedge clk);
        chk("irq_set_wins", 32'(irq), 32'd1);
        apb_write(10'h000, 32'h0000_0002, 1'b0);
        idle(1'b0);

        // Back-to-back write then read
        apb_write(10'h000, 32'h0000_0001, 1'b0);
        b2b_wr = cap_wr;
        apb_read(10'h004, 32'h1234_5678);
        chk("b2b_wr_en", 32'(b2b_wr), 32'd1);
        chk("b2b_rd_en", 32'(cap_rd), 32'd1);
        chk("b2b_rd_t1_pready", 32'(cap_pready1), 32'd0);
        chk("b2b_rd_t2_prdata", cap_prdata2, 32'h1234_5678);
        idle(1'b0);

`ifdef APB_ADDR_CHECK_EN
        apb_read(10'h008, 32'h0000_0055);
        chk("err_rd_pready", 32'(cap_pready1), 32'd1);
        chk("err_rd_pslverr", 32'(cap_pslverr1), 32'd1);
        chk("err_rd_strobe", 32'(cap_rd), 32'd0);
        idle(1'b0);
        apb_write(10'h004, 32'h0000_0009, 1'b0);
        chk("err_wr_pready", 32'(cap_pready1), 32'd1);
        chk("err_wr_pslverr", 32'(cap_pslverr1), 32'd1);
        chk("err_wr_strobe", 32'(cap_wr), 32'd0);
        idle(1'b0);
`else
        apb_read(10'h008, 32'h0000_0055);
        chk("fwd_rd_en", 32'(cap_rd), 32'd1);
        chk("fwd_pslverr", 32'(cap_pslverr1), 32'd0);
        chk("fwd_prdata", cap_prdata2, 32'h0000_0055);
        idle(1'b0);
`endif

        // Reset asserted during RD1 with irq pending
        idle(1'b1);
        idle(1'b0);
        cyc_start();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 10'h004; pwdata = 32'h0000_0777;
        set_idle_exp();
        cyc_start();
        penable = 1'b1;
        #1;
        rst_n = 1'b0;
        psel = 1'b0; penable = 1'b0; overflow = 1'b0;
        set_idle_exp();
        exp_addr = 10'd0; exp_wdata = 32'd0;
        #1;
        chk("mid_rst_rd_en", 32'(rd_en), 32'd0);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_addr", 32'(addr), 32'd0);
        chk("mid_rst_wdata", wdata, 32'd0);
        chk("mid_rst_pready", 32'(pready), 32'd0);
        chk("mid_rst_pslverr", 32'(pslverr), 32'd0);
        chk("mid_rst_prdata", prdata, 32'd0);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        apb_read(10'h004, 32'h0000_BEEF);
        chk("post_rst_pready", 32'(cap_pready2), 32'd1);
        chk("post_rst_prdata", cap_prdata2, 32'h0000_BEEF);
        idle(1'b0);
        idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_reg_bridge.md
# apb_reg_bridge

APB3 slave front-end for the counter register block. Converts APB transfers into the single-cycle `wr_en`/`rd_en` strobes, `addr` and `wdata` that the register block consumes, and returns its registered `rdata` as `prdata`. Also turns the register block's `overflow` level into a sticky `irq` that software clears through the existing control-register clear command. Sits directly upstream of the counter register block, between the system APB interconnect and the block.

## Interface
- `ADDR_W`, 10: APB and register address width.
- `DATA_W`, 32: data width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `psel` in 1: APB select.
- `penable` in 1: APB access phase.
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in ADDR_W: byte address.
- `pwdata` in DATA_W: write data.
- `prdata` out DATA_W: read data; valid only while `pready` is high on a read, 0 otherwise.
- `pready` out 1: transfer complete.
- `pslverr` out 1: error response, qualified by `pready`.
- `wr_en` out 1: one-cycle write strobe to the register block.
- `rd_en` out 1: one-cycle read strobe to the register block.
- `addr` out ADDR_W: register address; held from the strobe until the next transfer.
- `wdata` out DATA_W: register write data; held like `addr`.
- `rdata` in DATA_W: register block read data, registered, valid one cycle after `rd_en`.
- `overflow` in 1: counter overflow level from the register block.
- `irq` out 1: sticky overflow interrupt.

## Operation
- FSM states: IDLE, WR, RD1, RD2, ERR. All outputs are registered except `pready`, `pslverr` and `prdata`, which decode from state.
- IDLE, on `psel & ~penable` (setup phase):
  - Capture `paddr` into `addr` and `pwdata` into `wdata`.
  - Go to ERR if the address is invalid. Otherwise go to WR if `pwrite`, else RD1.
  - `penable` high in IDLE without a preceding setup phase is ignored.
- WR: `wr_en=1`, `pready=1`. Next state IDLE.
- RD1: `rd_en=1`, `pready=0`. Next state RD2.
- RD2: `pready=1`, `prdata=rdata`. Next state IDLE.
- ERR: `pready=1`, `pslverr=1`, `prdata=0`, no strobe. Next state IDLE.
- `psel` low while in WR, RD1 or RD2 aborts the transfer to IDLE. Strobes already issued are not retracted.
- irq:
  - `overflow_q` is a registered copy of `overflow`.
  - `irq` sets on `overflow & ~overflow_q`.
  - `irq` clears when WR issues to `CTRL_ADDR` with `wdata[CTRL_CLR_BIT]=1`.
  - If set and clear occur in the same cycle, set wins.
- Reset: state IDLE. `wr_en`, `rd_en`, `addr`, `wdata`, `prdata`, `pready`, `pslverr`, `irq` and `overflow_q` are all 0. Reset mid-transfer drops the transfer without completing it.

## Timing
- Write: setup at T0, access at T1. `wr_en` and `pready` are high in T1, giving 2 APB cycles and zero wait states.
- Read: setup at T0, `rd_en` in T1, `pready` with `prdata` in T2. This is 3 cycles with one wait state.
- Error: setup at T0, `pready`/`pslverr` in T1.
- Back-to-back: the next setup phase may occur in the cycle after `pready`. The bridge is in IDLE then, so no bubble is added.
- `wr_en`/`rd_en` are never high simultaneously and never high for two consecutive cycles.
- `irq` rises one cycle after the sampled rising edge of `overflow`.

## Configuration
- `APB_ADDR_CHECK_EN` defined:
  - Only `CTRL_ADDR` (0x000) and `COUNT_ADDR` (0x004) are valid.
  - Writes to `COUNT_ADDR` are also invalid, since it is read-only.
  - Invalid accesses go to ERR.
- Undefined: every address is forwarded, ERR is unreachable, and `pslverr` is tied 0.

## Structure
- Package `apb_reg_pkg`:
  - state enum
  - `CTRL_ADDR`=10'h000, `COUNT_ADDR`=10'h004
  - `CTRL_START_BIT`=0, `CTRL_CLR_BIT`=1
- Sub-module `irq_edge_latch`: holds `overflow_q` and `irq`, with the edge-detect set, clear input and set-priority logic.

## Test plan
- Write 0x000 = 0x00000001 → `wr_en` high exactly in T1, `addr`=0x000, `wdata`=0x1, `pready` high in T1, `pslverr`=0.
- Read 0x004 with the register block returning 0x0000002A → `rd_en` in T1, `pready` in T2, `prdata`=0x0000002A. `prdata`=0 in every other cycle.
- Raise `overflow` → `irq`=1 one cycle later and remaining 1 after `overflow` falls. Write 0x000 = 0x00000002 → `irq`=0 after the WR cycle. Repeat with the overflow edge in the same cycle as the clear → `irq` stays 1.
- Back-to-back write then read with no idle cycle → both complete. Strobes appear in consecutive access phases, and the read takes 3 cycles.
- With `APB_ADDR_CHECK_EN`: read 0x008 and write 0x004 → each gets `pready`=`pslverr`=1 in T1 with no strobe. Without the macro: read 0x008 → `rd_en` issued, `pslverr`=0.
- Assert `rst_n` low during RD1 → all outputs 0 immediately. After release, a new read completes normally.
